// File: rtl/mem_dump_tx.sv
// Reads a block of 32-bit words over a RIB master port and streams them out of a
// UART (8N1, little-endian bytes) followed by a two's-complement checksum byte.
module mem_dump_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [15:0] word_cnt_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        tx_pin,
    output logic        busy_o,
    output logic        done_o
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] READ   = 3'd1;
    localparam logic [2:0] SEND   = 3'd2;
    localparam logic [2:0] CHKSUM = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic [7:0]    chk_q, chk_d;
    logic          chk_pend_q, chk_pend_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic       bit_end;
    logic       frame_end;
    logic       frame_start;
    logic [7:0] frame_byte;
    logic [1:0] next_idx;
    logic [7:0] next_byte;

    assign bit_end   = (baud_cnt_q == BAUD_LAST);
    assign frame_end = bit_end && (bit_idx_q == 4'd9);
    assign next_idx  = byte_idx_q + 2'd1;

    always_comb begin
        case (next_idx)
            2'd0:    next_byte = data_q[7:0];
            2'd1:    next_byte = data_q[15:8];
            2'd2:    next_byte = data_q[23:16];
            default: next_byte = data_q[31:24];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        chk_d       = chk_q;
        chk_pend_d  = chk_pend_q;
        byte_idx_d  = byte_idx_q;
        bit_idx_d   = bit_idx_q;
        baud_cnt_d  = baud_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        frame_start = 1'b0;
        frame_byte  = 8'h00;

        // Bit serializer: shift register holds {stop, data}, start bit is driven on frame_start.
        if (state_q == SEND || state_q == CHKSUM) begin
            if (bit_end) begin
                baud_cnt_d = '0;
                if (!frame_end) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_cnt_d = baud_cnt_q + CW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cnt_d      = word_cnt_i;
                    chk_d      = 8'h00;
                    byte_idx_d = 2'd0;
                    if (word_cnt_i != 16'd0) begin
                        state_d    = READ;
                        mem_addr_d = base_addr_i & 32'hFFFF_FFFC;
                    end else begin
                        state_d    = CHKSUM;
                        chk_pend_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (mem_ready_i) begin
                    data_d      = mem_rdata_i;
                    byte_idx_d  = 2'd0;
                    frame_start = 1'b1;
                    frame_byte  = mem_rdata_i[7:0];
                    chk_d       = chk_q + mem_rdata_i[7:0];
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (frame_end) begin
                    if (byte_idx_q == 2'd3) begin
                        cnt_d = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d     = CHKSUM;
                            frame_start = 1'b1;
                            frame_byte  = ~chk_q + 8'd1;
                        end else begin
                            state_d    = READ;
                            mem_addr_d = mem_addr_q + 32'd4;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        byte_idx_d  = next_idx;
                        frame_start = 1'b1;
                        frame_byte  = next_byte;
                        chk_d       = chk_q + next_byte;
                    end
                end
            end
            CHKSUM: begin
                // An empty dump arrives here without a frame in flight; launch it one cycle later.
                if (chk_pend_q) begin
                    chk_pend_d  = 1'b0;
                    frame_start = 1'b1;
                    frame_byte  = ~chk_q + 8'd1;
                end else if (frame_end) begin
                    state_d = DONE;
                    tx_d    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (frame_start) begin
            tx_d       = 1'b0;
            baud_cnt_d = '0;
            bit_idx_d  = 4'd0;
            shift_d    = {1'b1, frame_byte};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mem_addr_q <= 32'h0;
            cnt_q      <= 16'h0;
            data_q     <= 32'h0;
            chk_q      <= 8'h00;
            chk_pend_q <= 1'b0;
            byte_idx_q <= 2'd0;
            bit_idx_q  <= 4'd0;
            baud_cnt_q <= '0;
            shift_q    <= 9'h1FF;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            chk_q      <= chk_d;
            chk_pend_q <= chk_pend_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    assign mem_req_o  = (state_q == READ);
    assign mem_we_o   = 1'b0;
    assign mem_addr_o = mem_addr_q;
    assign tx_pin     = tx_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: a memory responder and a UART receiver pop expected
// addresses/bytes from scoreboard queues filled by each scenario task.
module tb_mem_dump_tx;

    localparam int BD = 4;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] word_cnt_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;
    logic        tx_pin;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;
    int frames_started = 0;
    int done_pulses = 0;
    int req_cycles = 0;
    int mem_wait = 0;
    bit spurious_ready = 0;

    logic [7:0]  exp_byte_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] mem_data_q[$];
    int          frame_cyc_q[$];

    mem_dump_tx #(.BAUD_DIV(BD)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .word_cnt_i  (word_cnt_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i),
        .tx_pin      (tx_pin),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cycle_cnt++;
    end

    initial forever begin
        @(negedge clk);
        if (done_o === 1'b1) done_pulses++;
        if (mem_req_o === 1'b1) req_cycles++;
    end

    // Memory responder: answers each request after mem_wait wait cycles and checks its address.
    initial begin : mem_model
        bit in_req;
        int wcnt;
        int hold;
        logic [31:0] ea;
        in_req = 1'b0;
        wcnt = 0;
        hold = 0;
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req_o === 1'b1) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wcnt = 0;
                    hold = 0;
                    checks++;
                    if (exp_addr_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL mem_addr: unexpected request at %08h, expected no request", mem_addr_o);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        if (mem_addr_o !== ea) begin
                            errors++;
                            $display("[TB] FAIL mem_addr: got %08h, expected %08h", mem_addr_o, ea);
                        end
                    end
                end
                hold++;
                if (wcnt == mem_wait) begin
                    mem_ready_i = 1'b1;
                    mem_rdata_i = (mem_data_q.size() > 0) ? mem_data_q.pop_front() : 32'h0;
                end else begin
                    mem_ready_i = 1'b0;
                end
                wcnt++;
            end else begin
                if (in_req) begin
                    in_req = 1'b0;
                    checks++;
                    if (hold != mem_wait + 1) begin
                        errors++;
                        $display("[TB] FAIL req_hold: mem_req_o high %0d cycles, expected %0d", hold, mem_wait + 1);
                    end
                end
                mem_ready_i = spurious_ready;
                mem_rdata_i = spurious_ready ? 32'hDEAD_BEEF : 32'h0;
            end
        end
    end

    // UART receiver: decodes 8N1 frames, checks every bit is held BD cycles, pops expected bytes.
    initial begin : uart_monitor
        bit prev;
        bit aborted;
        bit stable;
        logic bv;
        logic [7:0] rx;
        logic [7:0] exp_b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && prev && tx_pin === 1'b0) begin
                frames_started++;
                frame_cyc_q.push_back(cycle_cnt);
                aborted = 1'b0;
                stable = 1'b1;
                rx = 8'h00;
                bv = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    for (int j = 0; j < BD; j++) begin
                        if (k != 0 || j != 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (j == 0) bv = tx_pin;
                        else if (tx_pin !== bv) stable = 1'b0;
                    end
                    if (aborted) break;
                    if (k == 0 && bv !== 1'b0) stable = 1'b0;
                    if (k == 9 && bv !== 1'b1) stable = 1'b0;
                    if (k >= 1 && k <= 8) rx[k-1] = bv;
                end
                if (!aborted) begin
                    checks++;
                    if (!stable) begin
                        errors++;
                        $display("[TB] FAIL frame_bits: byte %02h had a start/stop or data bit not held for %0d cycles", rx, BD);
                    end
                    checks++;
                    if (exp_byte_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL tx_byte: got unexpected frame %02h, expected no frame", rx);
                    end else begin
                        exp_b = exp_byte_q.pop_front();
                        if (rx !== exp_b) begin
                            errors++;
                            $display("[TB] FAIL tx_byte: got %02h, expected %02h", rx, exp_b);
                        end
                    end
                end
            end
            prev = tx_pin;
        end
    end

    initial begin
        #400000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not finish in time (got timeout, expected completion)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_word(input logic [31:0] w);
        exp_byte_q.push_back(w[7:0]);
        exp_byte_q.push_back(w[15:8]);
        exp_byte_q.push_back(w[23:16]);
        exp_byte_q.push_back(w[31:24]);
    endtask

    task automatic pulse_start(input logic [31:0] base, input logic [15:0] cnt, output int acc_cyc);
        @(negedge clk);
        base_addr_i = base;
        word_cnt_i  = cnt;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
        base_addr_i = $urandom;
        word_cnt_i  = 16'($urandom);
        acc_cyc     = cycle_cnt;
    endtask

    task automatic wait_done(input int budget, output bit seen, output int cyc);
        seen = 1'b0;
        cyc = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (done_o === 1'b1) begin
                seen = 1'b1;
                cyc = cycle_cnt;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        bit glitch;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tx_pin !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b, expected 1", tx_pin); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b, expected 0", mem_req_o); end
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b, expected 0", mem_we_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %08h, expected 0", mem_addr_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", done_o); end
        rst_n = 1'b1;
        glitch = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tx_pin !== 1'b1 || busy_o !== 1'b0 || mem_req_o !== 1'b0) glitch = 1'b1;
        end
        checks++; if (glitch) begin errors++; $display("[TB] FAIL reset_exit: got activity after release, expected idle"); end
    endtask

    task automatic test_single_word();
        int a, d, dp;
        bit seen;
        mem_wait = 0;
        exp_addr_q.push_back(32'h1000_0000);
        mem_data_q.push_back(32'h1234_5678);
        push_word(32'h1234_5678);
        // 0x78+0x56+0x34+0x12 = 0x114 -> 0x14, so the checksum byte is 0x100-0x14.
        exp_byte_q.push_back(8'hEC);
        dp = done_pulses;
        pulse_start(32'h1000_0000, 16'd1, a);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b, expected 1", busy_o); end
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("[TB] FAIL single_we: got %b, expected 0", mem_we_o); end
        wait_done(400, seen, d);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL single_done: got 0, expected done_o within 400 cycles"); end
        checks++; if (d - a < 1 + 40*BD + 10*BD) begin errors++; $display("[TB] FAIL single_latency: got %0d, expected >= %0d", d - a, 1 + 50*BD); end
        repeat (5) @(negedge clk);
        checks++; if (done_pulses - dp != 1) begin errors++; $display("[TB] FAIL single_done_pulses: got %0d, expected 1", done_pulses - dp); end
        checks++; if (exp_byte_q.size() != 0) begin errors++; $display("[TB] FAIL single_bytes_left: got %0d, expected 0", exp_byte_q.size()); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end: got %b, expected 0", busy_o); end
    endtask

    task automatic test_zero_count();
        int a, d, r;
        bit seen;
        spurious_ready = 1'b1;
        exp_byte_q.push_back(8'h00);
        r = req_cycles;
        pulse_start(32'h5000_0000, 16'd0, a);
        wait_done(200, seen, d);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL zero_done: got 0, expected done_o within 200 cycles"); end
        checks++; if (d - a < 1 + 10*BD) begin errors++; $display("[TB] FAIL zero_latency: got %0d, expected >= %0d", d - a, 1 + 10*BD); end
        checks++; if (req_cycles != r) begin errors++; $display("[TB] FAIL zero_req: got %0d request cycles, expected 0", req_cycles - r); end
        checks++; if (exp_byte_q.size() != 0) begin errors++; $display("[TB] FAIL zero_bytes_left: got %0d, expected 0", exp_byte_q.size()); end
        checks++; if (mem_addr_o !== 32'h1000_0000) begin errors++; $display("[TB] FAIL zero_addr_hold: got %08h, expected 10000000", mem_addr_o); end
        spurious_ready = 1'b0;
    endtask

    task automatic test_wait_states();
        int a, d;
        bit seen;
        mem_wait = 3;
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0000_0000);
        mem_data_q.push_back(32'h0000_00FF);
        mem_data_q.push_back(32'h0000_0001);
        push_word(32'h0000_00FF);
        push_word(32'h0000_0001);
        exp_byte_q.push_back(8'h00);
        pulse_start(32'hFFFF_FFFC, 16'd2, a);
        wait_done(1000, seen, d);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL wait_done: got 0, expected done_o within 1000 cycles"); end
        checks++; if (d - a < 1 + 2*(3 + 40*BD) + 10*BD) begin errors++; $display("[TB] FAIL wait_latency: got %0d, expected >= %0d", d - a, 1 + 2*(3 + 40*BD) + 10*BD); end
        checks++; if (exp_byte_q.size() != 0) begin errors++; $display("[TB] FAIL wait_bytes_left: got %0d, expected 0", exp_byte_q.size()); end
        checks++; if (exp_addr_q.size() != 0) begin errors++; $display("[TB] FAIL wait_addr_left: got %0d, expected 0", exp_addr_q.size()); end
        mem_wait = 0;
    endtask

    task automatic test_start_while_busy();
        int a, d, dp, r, dummy;
        bit seen;
        exp_addr_q.push_back(32'h2000_0004);
        mem_data_q.push_back(32'hA5C3_0F81);
        push_word(32'hA5C3_0F81);
        exp_byte_q.push_back(8'h08);
        dp = done_pulses;
        pulse_start(32'h2000_0004, 16'd1, a);
        repeat (60) @(negedge clk);
        pulse_start(32'h3000_0000, 16'd5, dummy);
        wait_done(400, seen, d);
        r = req_cycles;
        checks++; if (!seen) begin errors++; $display("[TB] FAIL busy_done: got 0, expected done_o within 400 cycles"); end
        repeat (60) @(negedge clk);
        checks++; if (exp_byte_q.size() != 0) begin errors++; $display("[TB] FAIL busy_bytes_left: got %0d, expected 0", exp_byte_q.size()); end
        checks++; if (done_pulses - dp != 1) begin errors++; $display("[TB] FAIL busy_done_pulses: got %0d, expected 1", done_pulses - dp); end
        checks++; if (req_cycles != r) begin errors++; $display("[TB] FAIL busy_restart: got %0d request cycles after done, expected 0", req_cycles - r); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL busy_end: got %b, expected 0", busy_o); end
    endtask

    task automatic test_reset_mid();
        int a, d, fs0;
        bit seen, reached, glitch;
        exp_addr_q.push_back(32'h1000_0000);
        mem_data_q.push_back(32'h1234_5678);
        push_word(32'h1234_5678);
        exp_byte_q.push_back(8'hEC);
        fs0 = frames_started;
        pulse_start(32'h1000_0000, 16'd1, a);
        reached = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            @(negedge clk);
            #1;
            if (frames_started >= fs0 + 3) reached = 1'b1;
        end
        checks++; if (!reached) begin errors++; $display("[TB] FAIL rmid_byte2: got %0d frames, expected 3 within 400 cycles", frames_started - fs0); end
        repeat (4*BD + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx_pin !== 1'b1) begin errors++; $display("[TB] FAIL rmid_tx: got %b, expected 1", tx_pin); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_req: got %b, expected 0", mem_req_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy: got %b, expected 0", busy_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL rmid_addr: got %08h, expected 0", mem_addr_o); end
        checks++; if (exp_byte_q.size() != 3) begin errors++; $display("[TB] FAIL rmid_bytes_sent: got %0d left, expected 3", exp_byte_q.size()); end
        exp_byte_q.delete();
        exp_addr_q.delete();
        mem_data_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        glitch = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx_pin !== 1'b1 || busy_o !== 1'b0) glitch = 1'b1;
        end
        checks++; if (glitch) begin errors++; $display("[TB] FAIL rmid_idle: got activity after release, expected idle"); end
        exp_addr_q.push_back(32'h0000_0040);
        mem_data_q.push_back(32'h0000_0080);
        push_word(32'h0000_0080);
        exp_byte_q.push_back(8'h80);
        pulse_start(32'h0000_0040, 16'd1, a);
        wait_done(400, seen, d);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL rmid_redo_done: got 0, expected done_o within 400 cycles"); end
        checks++; if (exp_byte_q.size() != 0) begin errors++; $display("[TB] FAIL rmid_redo_bytes: got %0d left, expected 0", exp_byte_q.size()); end
    endtask

    task automatic test_back_to_back();
        int a, d, fs, r;
        bit seen;
        exp_addr_q.push_back(32'h0000_0100);
        mem_data_q.push_back(32'hDEAD_BEEF);
        push_word(32'hDEAD_BEEF);
        exp_byte_q.push_back(8'hC8);
        frame_cyc_q.delete();
        pulse_start(32'h0000_0103, 16'd1, a);
        wait_done(400, seen, d);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL b2b_done: got 0, expected done_o within 400 cycles"); end
        checks++; if (frame_cyc_q.size() != 5) begin errors++; $display("[TB] FAIL b2b_frames: got %0d, expected 5", frame_cyc_q.size()); end
        for (int i = 1; i < frame_cyc_q.size(); i++) begin
            checks++;
            if (frame_cyc_q[i] - frame_cyc_q[i-1] != 10*BD) begin
                errors++;
                $display("[TB] FAIL b2b_spacing: frame %0d got %0d cycles, expected %0d", i, frame_cyc_q[i] - frame_cyc_q[i-1], 10*BD);
            end
        end
        if (frame_cyc_q.size() > 0) begin
            checks++;
            if (d - frame_cyc_q[frame_cyc_q.size()-1] != 10*BD) begin
                errors++;
                $display("[TB] FAIL b2b_done_time: got %0d cycles after checksum start, expected %0d", d - frame_cyc_q[frame_cyc_q.size()-1], 10*BD);
            end
        end
        // Start pulse landing exactly in the DONE cycle must be dropped.
        fs = frames_started;
        r = req_cycles;
        base_addr_i = 32'h0;
        word_cnt_i  = 16'd1;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_start_busy: got %b, expected 0", busy_o); end
        repeat (60) @(negedge clk);
        checks++; if (frames_started != fs || req_cycles != r) begin errors++; $display("[TB] FAIL b2b_done_start_ignored: got %0d frames / %0d req cycles, expected 0 / 0", frames_started - fs, req_cycles - r); end
    endtask

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        base_addr_i = 32'h0;
        word_cnt_i  = 16'h0;
        test_reset();
        test_single_word();
        test_zero_count();
        test_wait_states();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
